// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_pkg                                                            |
// | Shared PS/2 types, frame constants and keyboard command bytes.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    REQ       = 3'd2,
    SHIFT     = 3'd3,
    WAIT_IDLE = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // Bits shifted after the start bit: data LSB first, odd parity, stop.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_sync_edge                                                      |
// | Two-flop synchronizers for PS/2 clock and data, clock fall detect. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic r_clk_meta;
  logic r_clk_sync;
  logic r_clk_prev;
  logic r_data_meta;
  logic r_data_sync;

  // Reset to the idle-high bus level so release of reset never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= i_ps2_clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= i_ps2_data;
      r_data_sync <= r_data_meta;
    end
  end

  assign o_clk_sync  = r_clk_sync;
  assign o_data_sync = r_data_sync;
  assign o_clk_fall  = r_clk_prev & ~r_clk_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx                                                        |
// | PS/2 host-to-device command transmitter with ACK check & timeout.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       ACK_IDX      = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e       r_state;
  ps2_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit_idx;
  logic [9:0]       r_frame;
  logic             r_clk_oe;
  logic             r_data_oe;

  logic w_clk_sync;
  logic w_data_sync;
  logic w_clk_fall;
  logic w_accept;
  logic w_timeout;

  ps2_sync_edge u_sync (
    .clk         (clock),
    .rst         (reset),
    .i_ps2_clk   (ps2_clk_in),
    .i_ps2_data  (ps2_data_in),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  assign w_accept  = tx_valid & (r_state == IDLE);
  assign w_timeout = ((r_state == SHIFT) || (r_state == WAIT_IDLE)) && (r_cnt == TIMEOUT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_next = INHIBIT;
      INHIBIT:   if (r_cnt == INHIBIT_LAST) w_state_next = REQ;
      REQ:       w_state_next = SHIFT;
      SHIFT: begin
        // Timeout wins over a fall landing in the same cycle.
        if (w_timeout) begin
          w_state_next = ERROR;
        end else if (w_clk_fall && (r_bit_idx == ACK_IDX)) begin
          w_state_next = w_data_sync ? ERROR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (w_timeout) begin
          w_state_next = ERROR;
        end else if (w_clk_sync && w_data_sync) begin
          w_state_next = DONE;
        end
      end
      DONE:      w_state_next = IDLE;
      ERROR:     w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // Line drivers are registered from the next state so the pins never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_bit_idx <= 4'd0;
      r_frame   <= 10'd0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
    end else begin
      r_clk_oe <= (w_state_next == INHIBIT) || (w_state_next == REQ);

      case (w_state_next)
        REQ:     r_data_oe <= 1'b1;
        SHIFT: begin
          if ((r_state == SHIFT) && w_clk_fall && (r_bit_idx < ACK_IDX)) begin
            r_data_oe <= ~r_frame[r_bit_idx];
          end
        end
        default: r_data_oe <= 1'b0;
      endcase

      if (w_accept) begin
        r_frame   <= ps2_tx_frame(tx_data);
        r_cnt     <= '0;
        r_bit_idx <= 4'd0;
      end else begin
        case (r_state)
          INHIBIT: begin
            if (r_cnt != INHIBIT_LAST) r_cnt <= r_cnt + CNT_W'(1);
          end
          REQ: begin
            r_cnt     <= '0;
            r_bit_idx <= 4'd0;
          end
          SHIFT: begin
            if (r_cnt != TIMEOUT_LAST) r_cnt <= r_cnt + CNT_W'(1);
            if (w_clk_fall && (r_bit_idx < ACK_IDX)) r_bit_idx <= r_bit_idx + 4'd1;
          end
          WAIT_IDLE: begin
            if (r_cnt != TIMEOUT_LAST) r_cnt <= r_cnt + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    tx_ready    = (r_state == IDLE);
    tx_busy     = (r_state != IDLE);
    tx_done     = (r_state == DONE);
    tx_error    = (r_state == ERROR);
    ps2_clk_oe  = r_clk_oe;
    ps2_data_oe = r_data_oe;
  end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the opposite direction to the existing keyboard receiver. It sends command bytes to the keyboard, e.g. 0xED set-LEDs or 0xFF reset, issued by the CPU through a memory-mapped register. It drives the open-drain PS2_CLK/PS2_DATA lines through output-enable signals, runs the standard request-to-send sequence, and checks the device acknowledge. It runs in the 50 MHz domain beside the keyboard block.

Parameters:
INHIBIT_CYC, 5000, clock-low inhibit time in clock cycles (100 us at 50 MHz).
TIMEOUT_CYC, 750000, maximum cycles from SHIFT entry to frame completion (15 ms).

Ports:
clock  in  1  system clock (50 MHz); sole clock.
reset  in  1  asynchronous, active-high reset.
tx_data  in  8  command byte to send.
tx_valid  in  1  request; accepted when tx_valid & tx_ready.
tx_ready  out  1  high only in IDLE.
tx_busy  out  1  high in any state except IDLE; the keyboard receiver ignores frames while it is high.
tx_done  out  1  one-cycle pulse on an acknowledged frame with the bus back to idle.
tx_error  out  1  one-cycle pulse on a NAK or a timeout.
ps2_clk_in  in  1  raw PS2_CLK pin level (asynchronous).
ps2_data_in  in  1  raw PS2_DATA pin level (asynchronous).
ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
ps2_data_oe  out  1  1 = pull PS2_DATA low; 0 = release.

Behaviour:
- Reset (async): state = IDLE; ps2_clk_oe = ps2_data_oe = 0 in the same instant; tx_done = tx_error = 0; tx_ready = 1; tx_busy = 0. Reset in mid-frame abandons the frame with no done/error pulse.
- Input conditioning: ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer.
- fall = synced_clk_prev & ~synced_clk. fall is valid 2–3 cycles after the pin edge.
- Frame register on accept: {stop = 1, parity = ~^tx_data, tx_data}, sent LSB first. bit_idx is 4 bits and counts 0..10.
- IDLE: both oe = 0.
  - On accept, latch the frame, clear cnt, and go to INHIBIT.
  - tx_valid while not ready is ignored and is not queued.
- INHIBIT: clk_oe = 1, data_oe = 0. cnt counts up; at cnt == INHIBIT_CYC-1, go to REQ.
- REQ (exactly 1 cycle): clk_oe = 1, data_oe = 1 (start bit). Then go to SHIFT with clk_oe = 0, cnt = 0, bit_idx = 0.
- SHIFT: data_oe holds the last value set.
  - On each fall with bit_idx 0..9: data_oe <= ~frame[bit_idx], effective next cycle; bit_idx++.
  - bit_idx 9 is the stop bit, which releases the line (data_oe = 0).
  - On the fall with bit_idx == 10 (11th falling edge), sample synced_data. 0 = ACK: go to WAIT_IDLE. 1 = NAK: go to ERROR.
- WAIT_IDLE: both oe = 0. When synced_clk & synced_data are both 1, go to DONE.
- DONE: tx_done = 1 for 1 cycle, then IDLE.
- ERROR: both oe = 0; tx_error = 1 for 1 cycle, then IDLE.
- Timeout: cnt increments every cycle in SHIFT and WAIT_IDLE. At cnt == TIMEOUT_CYC-1, go to ERROR; this has priority over a coincident fall.
- cnt width is $clog2(max(INHIBIT_CYC, TIMEOUT_CYC)) and it never wraps, because the state exits before saturation.
- The host never drives a line high. The oe outputs come directly from registers, so there are no glitches.

Decomposition:
- ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, SHIFT, WAIT_IDLE, DONE, ERROR};
  - PS2_FRAME_BITS = 11;
  - command constants PS2_CMD_SET_LED = 8'hED, PS2_CMD_RESET = 8'hFF, PS2_ACK = 8'hFA.
- One sub-module: ps2_sync_edge (2-FF synchronizers plus falling-edge detect on clk, synced data out). The keyboard receiver shares it.

Test Plan:
Bench settings for all scenarios: INHIBIT_CYC = 10, TIMEOUT_CYC = 400, device model clock period 40 cycles.
1. Send 0xED, device ACKs. Device samples start 0, then 1,0,1,1,0,1,1,1, then parity 1, then stop 1. tx_done pulses once, tx_error stays 0, tx_ready returns to 1.
2. Timing check on 0xED. ps2_clk_oe is high exactly 10 cycles, then REQ is 1 cycle with both oe = 1. clk_oe falls on the following cycle while data_oe stays 1.
3. Parity: 0x00 gives parity 1; 0x01 gives parity 0; 0xFF gives parity 1. Each is checked by the device model.
4. NAK: device leaves data high at the 11th falling edge. tx_error pulses 1 cycle, tx_done stays 0, both oe = 0.
5. No device clock after REQ. tx_error pulses exactly 400 cycles after SHIFT entry, both oe = 0, then IDLE. Pulse tx_valid during INHIBIT: no second frame is sent.
6. Assert reset after the 4th falling edge. Both oe are 0 with no clock edge needed, tx_busy = 0, no pulses. After reset releases, sending 0xFF completes with tx_done.
